// File: rtl/mac_pkg.sv
// Shared types and helpers for the LANES-wide dot-product MAC.
package mac_pkg;

  typedef enum logic [1:0] {IDLE, MUL, ACC} mac_state_e;

  // Widest signed value sat_clamp can handle; callers sign-extend into it.
  localparam int CLAMP_W = 128;

  // ovf is the LSB so callers can take {value[w-1:0], ovf} with one size cast.
  typedef struct packed {
    logic signed [CLAMP_W-1:0] value;
    logic                      ovf;
  } clamp_t;

  function automatic int prod_w(input int dw);
    return 2 * dw;
  endfunction

  function automatic clamp_t sat_clamp(input logic signed [CLAMP_W-1:0] value,
                                       input int width);
    logic signed [CLAMP_W-1:0] max_v;
    logic signed [CLAMP_W-1:0] min_v;
    clamp_t                    res;
    max_v = (CLAMP_W'(1) << (width - 1)) - CLAMP_W'(1);
    min_v = ~max_v;
    res.ovf = (value > max_v) || (value < min_v);
    if (value > max_v)      res.value = max_v;
    else if (value < min_v) res.value = min_v;
    else                    res.value = value;
    return res;
  endfunction

endpackage

// File: rtl/mac_seq_mult.sv
// One lane's signed multiplier: sign-magnitude, radix-2 shift-add, one bit per step.
module mac_seq_mult
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_W      = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             step,
  input  logic [DATA_WIDTH-1:0]            a,
  input  logic [DATA_WIDTH-1:0]            b,
  input  logic [CNT_W-1:0]                 cnt,
  output logic signed [prod_w(DATA_WIDTH)-1:0] product
);

  localparam int PW = prod_w(DATA_WIDTH);

  // Magnitudes are unsigned, so |-2^(DW-1)| = 2^(DW-1) is represented exactly.
  logic [DATA_WIDTH-1:0] mag_a_reg;
  logic [DATA_WIDTH-1:0] mag_b_reg;
  logic                  neg_reg;
  logic [PW-1:0]         acc_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      mag_a_reg <= '0;
      mag_b_reg <= '0;
      neg_reg   <= 1'b0;
      acc_reg   <= '0;
    end else if (start) begin
      mag_a_reg <= a[DATA_WIDTH-1] ? -a : a;
      mag_b_reg <= b[DATA_WIDTH-1] ? -b : b;
      neg_reg   <= a[DATA_WIDTH-1] ^ b[DATA_WIDTH-1];
      acc_reg   <= '0;
    end else if (step && mag_b_reg[cnt]) begin
      acc_reg <= acc_reg + ({{DATA_WIDTH{1'b0}}, mag_a_reg} << cnt);
    end
  end

  assign product = neg_reg ? -acc_reg : acc_reg;

endmodule

// File: rtl/mac_dot_unit.sv
// LANES-wide signed dot-product accumulator with saturating/wrapping accumulate.
module mac_dot_unit
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 4,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*DATA_WIDTH-1:0]   a_in,
  input  logic [LANES*DATA_WIDTH-1:0]   b_in,
  input  logic                          last,
  input  logic                          clr_acc,
  input  logic                          sat_mode,
  output logic [ACC_WIDTH-1:0]          accumulator,
  output logic                          done,
  output logic                          out_valid,
  output logic                          overflow
);

  localparam int PW    = prod_w(DATA_WIDTH);
  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  generate
    if (ACC_WIDTH < 2 * DATA_WIDTH + $clog2(LANES) || ACC_WIDTH + 1 > CLAMP_W) begin : g_bad_acc_width
      $error("mac_dot_unit: ACC_WIDTH too small for the lane sum or too wide for sat_clamp");
    end
  endgenerate

  mac_state_e state_reg, state_next;
  logic [CNT_W-1:0]            cnt_reg;
  logic                        last_lat_reg;
  logic                        sat_lat_reg;
  logic                        clr_lat_reg;
  logic signed [ACC_WIDTH-1:0] acc_reg;
  logic                        overflow_reg;
  logic                        done_reg;
  logic                        out_valid_reg;

  logic                        handshake;
  logic signed [PW-1:0]        lane_prod [LANES];
  logic signed [ACC_WIDTH:0]   sum;
  logic [ACC_WIDTH:0]          clamp_bits;

  assign in_ready  = (state_reg == IDLE) && !rst;
  assign handshake = in_valid && in_ready;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      mac_seq_mult #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_W      (CNT_W)
      ) u_mult (
        .clk     (clk),
        .rst     (rst),
        .start   (handshake),
        .step    (state_reg == MUL),
        .a       (a_in[gi*DATA_WIDTH +: DATA_WIDTH]),
        .b       (b_in[gi*DATA_WIDTH +: DATA_WIDTH]),
        .cnt     (cnt_reg),
        .product (lane_prod[gi])
      );
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (handshake) state_next = MUL;
      MUL:     if (cnt_reg == CNT_LAST) state_next = ACC;
      ACC:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One bit of headroom above ACC_WIDTH is enough to detect any single-beat overflow.
  always_comb begin
    if (clr_lat_reg) sum = '0;
    else             sum = (ACC_WIDTH + 1)'(acc_reg);
    for (int i = 0; i < LANES; i++) begin
      sum = sum + (ACC_WIDTH + 1)'(lane_prod[i]);
    end
  end

  assign clamp_bits = (ACC_WIDTH + 1)'(sat_clamp(CLAMP_W'(sum), ACC_WIDTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      last_lat_reg  <= 1'b0;
      sat_lat_reg   <= 1'b0;
      clr_lat_reg   <= 1'b0;
      acc_reg       <= '0;
      overflow_reg  <= 1'b0;
      done_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      done_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (handshake) begin
            last_lat_reg <= last;
            sat_lat_reg  <= sat_mode;
            clr_lat_reg  <= clr_acc;
            cnt_reg      <= '0;
          end else if (clr_acc) begin
            acc_reg      <= '0;
            overflow_reg <= 1'b0;
          end
        end
        MUL: cnt_reg <= cnt_reg + CNT_W'(1);
        ACC: begin
          if (sat_lat_reg) acc_reg <= clamp_bits[ACC_WIDTH:1];
          else             acc_reg <= sum[ACC_WIDTH-1:0];
          overflow_reg  <= (overflow_reg & ~clr_lat_reg) | clamp_bits[0];
          done_reg      <= 1'b1;
          out_valid_reg <= last_lat_reg;
        end
        default: ;
      endcase
    end
  end

  assign accumulator = acc_reg;
  assign overflow    = overflow_reg;
  assign done        = done_reg;
  assign out_valid   = out_valid_reg;

endmodule

// File: tb/tb_mac_dot_unit.sv
// Directed bench: a default-width unit and a 34-bit accumulator unit share one stimulus stream.
module tb_mac_dot_unit;

  localparam int DW = 16;
  localparam int LN = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic last = 1'b0;
  logic clr_acc = 1'b0;
  logic sat_mode = 1'b0;
  logic [LN*DW-1:0] a_in = '0;
  logic [LN*DW-1:0] b_in = '0;

  logic        ready_w, done_w, outv_w, ovf_w;
  logic [39:0] acc_w;
  logic        ready_n, done_n, outv_n, ovf_n;
  logic [33:0] acc_n;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mac_dot_unit #(.DATA_WIDTH(DW), .LANES(LN), .ACC_WIDTH(40)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready_w),
    .a_in(a_in), .b_in(b_in), .last(last), .clr_acc(clr_acc), .sat_mode(sat_mode),
    .accumulator(acc_w), .done(done_w), .out_valid(outv_w), .overflow(ovf_w)
  );

  mac_dot_unit #(.DATA_WIDTH(DW), .LANES(LN), .ACC_WIDTH(34)) dut_n (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready_n),
    .a_in(a_in), .b_in(b_in), .last(last), .clr_acc(clr_acc), .sat_mode(sat_mode),
    .accumulator(acc_n), .done(done_n), .out_valid(outv_n), .overflow(ovf_n)
  );

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack4(input int x0, input int x1, input int x2, input int x3);
    return {16'(x3), 16'(x2), 16'(x1), 16'(x0)};
  endfunction

  // Waits (bounded) for in_ready, presents one beat, returns #1 after the handshake edge.
  task automatic drive_beat(input logic [63:0] av, input logic [63:0] bv,
                            input logic lst, input logic sat, input logic clr);
    int guard = 0;
    while (ready_w !== 1'b1 && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    check("ready_before_beat", 64'(ready_w), 1);
    a_in = av; b_in = bv; last = lst; sat_mode = sat; clr_acc = clr; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    clr_acc  = 1'b0;
  endtask

  task automatic run_beat(input string tag, input logic [63:0] av, input logic [63:0] bv,
                          input logic lst, input logic sat, input logic clr,
                          input logic use_n, input longint exp_acc, input logic exp_ovf);
    logic signed [63:0] obs_acc;
    logic               obs_ovf;
    drive_beat(av, bv, lst, sat, clr);
    check({tag, "_busy_ready"}, 64'(ready_w), 0);
    repeat (DW) @(posedge clk);
    #1;
    check({tag, "_done_early"}, 64'(done_w), 0);
    check({tag, "_ready_acc"}, 64'(ready_w), 0);
    @(posedge clk); #1;
    obs_acc = use_n ? 64'($signed(acc_n)) : 64'($signed(acc_w));
    obs_ovf = use_n ? ovf_n : ovf_w;
    check({tag, "_done"}, 64'(done_w), 1);
    check({tag, "_out_valid"}, 64'(outv_w), 64'(lst));
    check({tag, "_acc"}, obs_acc, exp_acc);
    check({tag, "_ovf"}, 64'(obs_ovf), 64'(exp_ovf));
    check({tag, "_ready_after"}, 64'(ready_w), 1);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 64'(done_w), 0);
    check({tag, "_outv_pulse"}, 64'(outv_w), 0);
  endtask

  task automatic do_clear(input string tag);
    clr_acc = 1'b1;
    @(posedge clk); #1;
    clr_acc = 1'b0;
    check({tag, "_acc_w"}, 64'($signed(acc_w)), 0);
    check({tag, "_ovf_w"}, 64'(ovf_w), 0);
    check({tag, "_acc_n"}, 64'($signed(acc_n)), 0);
    check({tag, "_ovf_n"}, 64'(ovf_n), 0);
  endtask

  initial begin
    logic [63:0] mneg;
    int          seen_done;
    mneg = pack4(-32768, -32768, -32768, -32768);

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(ready_w), 0);
    check("rst_acc", 64'($signed(acc_w)), 0);
    check("rst_done", 64'(done_w), 0);
    check("rst_outv", 64'(outv_w), 0);
    check("rst_ovf", 64'(ovf_w), 0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 64'(ready_w), 1);
    do_clear("clr0");

    run_beat("dot1", pack4(10, 2, 100, 0), pack4(5, -3, 10, 0), 1, 1, 0, 0, 1044, 0);
    run_beat("clr_hs", pack4(1, 0, 0, 0), pack4(1, 0, 0, 0), 1, 1, 1, 0, 1, 0);
    run_beat("neg_max", pack4(-32768, 0, 0, 0), pack4(32767, 0, 0, 0), 1, 1, 1, 0, -1073709056, 0);

    do_clear("clr1");
    run_beat("two_a", pack4(1, 1, 1, 1), pack4(2, 2, 2, 2), 0, 1, 0, 0, 8, 0);
    run_beat("two_b", pack4(3, 0, 0, 0), pack4(4, 0, 0, 0), 1, 1, 0, 0, 20, 0);

    do_clear("clr2");
    run_beat("minsq_w", mneg, mneg, 1, 1, 0, 0, 64'sd4294967296, 0);
    check("minsq_n_acc", 64'($signed(acc_n)), 64'sd4294967296);
    check("minsq_n_ovf", 64'(ovf_n), 0);
    run_beat("sat_n", mneg, mneg, 1, 1, 0, 1, 64'sd8589934591, 1);
    check("sat_w_acc", 64'($signed(acc_w)), 64'sd8589934592);
    check("sat_w_ovf", 64'(ovf_w), 0);

    do_clear("clr3");
    run_beat("wrap1_n", mneg, mneg, 1, 0, 0, 1, 64'sd4294967296, 0);
    run_beat("wrap2_n", mneg, mneg, 1, 0, 0, 1, -64'sd8589934592, 1);
    run_beat("clr_hs_n", pack4(1, 0, 0, 0), pack4(1, 0, 0, 0), 1, 1, 1, 1, 1, 0);

    // Reset five cycles into a beat aborts it
    drive_beat(pack4(10, 2, 100, 0), pack4(5, -3, 10, 0), 1, 1, 0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_ready_in_rst", 64'(ready_w), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("abort_ready", 64'(ready_w), 1);
    check("abort_acc", 64'($signed(acc_w)), 0);
    check("abort_ovf", 64'(ovf_w), 0);
    seen_done = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done_w === 1'b1) seen_done++;
    end
    check("abort_no_done", 64'(seen_done), 0);
    run_beat("after_rst", pack4(7, 0, 0, 0), pack4(6, 0, 0, 0), 1, 1, 0, 0, 42, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mac_dot_unit.md
# mac_dot_unit

Parametrised successor to the single-lane MAC: a LANES-wide signed dot-product accumulator built on iterative shift-add multipliers. It has a valid/ready input handshake, per-beat completion, end-of-vector marking, and a selectable saturating or wrapping accumulator with a sticky overflow flag. It sits where the single-lane MAC sits today, feeding accumulated dot products to downstream filter/matrix logic.

## Interface
- DATA_WIDTH, 16, signed operand width per lane
- LANES, 4, multiplier lanes per beat
- ACC_WIDTH, 40, signed accumulator width; must be ≥ 2*DATA_WIDTH + $clog2(LANES) (elaboration-time check)
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  high only in IDLE and not in reset (combinational from state)
- a_in  in  LANES*DATA_WIDTH  lane i at [i*DATA_WIDTH +: DATA_WIDTH], signed
- b_in  in  LANES*DATA_WIDTH  same packing as a_in
- last  in  1  beat closes the current vector, sampled on handshake
- clr_acc  in  1  clear accumulator and overflow, sampled only in IDLE
- sat_mode  in  1  1 = saturate, 0 = wrap; sampled on handshake
- accumulator  out  ACC_WIDTH  signed running sum
- done  out  1  one-cycle pulse per completed beat
- out_valid  out  1  one-cycle pulse, coincident with done, when the beat had last=1
- overflow  out  1  sticky; set on any accumulate overflow

## Operation
- FSM states: IDLE, MUL, ACC.
- IDLE:
  - If in_valid && in_ready: capture a/b/last/sat_mode, capture clr_acc as clr_lat, go to MUL with cnt=0.
  - Else if clr_acc: accumulator<=0, overflow<=0.
- MUL:
  - Each lane multiplies sign-magnitude: |a|·|b| by radix-2 shift-add, one bit per cycle. The product sign is sign(a)^sign(b).
  - |−2^(DW−1)| must be handled as an unsigned DW-bit value.
  - Go to ACC after DATA_WIDTH cycles (cnt==DATA_WIDTH−1).
- ACC:
  - Sign-extend the lane products to ACC_WIDTH+1 bits and sum them. Base = 0 if clr_lat, else accumulator.
  - Overflow when the ACC_WIDTH+1-bit result does not fit ACC_WIDTH bits.
  - Saturating mode clamps to +2^(AW−1)−1 or −2^(AW−1). Wrapping mode keeps the low ACC_WIDTH bits.
  - Overflow sets the sticky flag in both modes. If clr_lat, overflow is first cleared, then set only by this beat.
  - done<=1, out_valid<=last_lat, go to IDLE.
- clr_acc during MUL/ACC is ignored.
- in_valid while busy: in_ready=0; operands must be held by the source.
- No output back-pressure; done/out_valid are pulses.

## Timing
- Reset values:
  - accumulator=0, done=0, out_valid=0, overflow=0, state=IDLE.
  - in_ready=0 while rst=1.
- Reset mid-operation aborts the beat: no done pulse, accumulator=0, in_ready=1 the cycle after rst deasserts.
- Handshake at edge E0. Multiply steps occur at E1..E_DW. Accumulate, done, and out_valid register at E_(DW+1).
  - Latency: DW+1 cycles (17 at default).
- done/out_valid are high for exactly the cycle following E_(DW+1). The accumulator is stable and valid in that cycle.
- Earliest next handshake is E_(DW+2).
  - Throughput: one beat per DW+2 cycles.

## Structure
- Package mac_pkg:
  - mac_state_e enum (IDLE, MUL, ACC).
  - Function sat_clamp(value, width) returning the clamped value plus an overflow bit.
  - Localparam helper PROD_W(DW)=2*DW.
- Sub-module mac_seq_mult: one lane's iterative signed multiplier (start, operands, DATA_WIDTH-step counter shared from parent, 2*DW product). Instantiated LANES times via generate.
- mac_dot_unit owns the FSM, lane-sum adder tree, clamp, and registers.

## Test plan
- Defaults. Reset, clr_acc, then one beat a={10,2,100,0}, b={5,−3,10,0}, last=1 → accumulator=1044 with done+out_valid at 17 cycles after handshake; in_ready low for cycles E1..E17.
- Two beats {1,1,1,1}·{2,2,2,2} (last=0) then {3,0,0,0}·{4,0,0,0} (last=1) → done on both beats, out_valid only on the second, accumulator=8 then 20.
- All lanes −32768·−32768, last=1 → accumulator=4294967296, overflow=0.
- ACC_WIDTH=34, two beats of the previous vector:
  - sat_mode=1 → 8589934591, overflow=1.
  - sat_mode=0 → −8589934592, overflow=1.
  - Then clr_acc in IDLE → 0, overflow=0.
- Accumulator at 1044, then beat {1,0,0,0}·{1,0,0,0} with clr_acc=1 in the handshake cycle → accumulator=1; overflow cleared.
- Beat {10,…}·{5,…} with rst asserted 5 cycles after handshake → no done pulse, accumulator=0, in_ready=1 the first cycle after rst deasserts; next beat 7·6 (lane 0 only) → 42.
